// File: rtl/icache_pkg.sv
// Shared types, default geometry and the address-split helper for the
// set-associative instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } icache_state_t;

    localparam int DEF_WAYS        = 2;
    localparam int DEF_SETS        = 8;
    localparam int DEF_BLOCK_WORDS = 2;

    typedef struct packed {
        logic [31:0] tag;
        logic [31:0] idx;
        logic [31:0] off;
    } addr_split_t;

    // Fields come back right-aligned; callers truncate to their own widths.
    function automatic addr_split_t split_addr(input logic [31:0] addr,
                                               input int idx_w,
                                               input int off_w);
        addr_split_t s;
        s.off = (addr >> 2) & ((32'd1 << off_w) - 32'd1);
        s.idx = (addr >> (2 + off_w)) & ((32'd1 << idx_w) - 32'd1);
        s.tag = addr >> (2 + off_w + idx_w);
        return s;
    endfunction

endpackage

// File: rtl/icache_fill_fsm.sv
// Miss handling: latches the missing block, streams it in word by word and
// tells the array when to commit or drop it.
module icache_fill_fsm
    import icache_pkg::*;
#(
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int IDX_W       = 3,
    parameter int TAG_W       = 26,
    parameter int WAY_W       = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        miss,
    input  logic [TAG_W-1:0]            miss_tag,
    input  logic [IDX_W-1:0]            miss_idx,
    input  logic [WAY_W-1:0]            victim,
    input  logic                        iwait,
    input  logic [31:0]                 iload,
    output icache_state_t               state,
    output logic                        iren,
    output logic [31:0]                 iaddr,
    output logic                        commit,
    output logic                        abort,
    output logic [TAG_W-1:0]            fill_tag,
    output logic [IDX_W-1:0]            fill_idx,
    output logic [WAY_W-1:0]            fill_way,
    output logic [BLOCK_WORDS-1:0][31:0] fill_data
);

    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int CNT_W = (OFF_W > 0) ? OFF_W : 1;
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(BLOCK_WORDS - 1);

    icache_state_t                state_r, next_s;
    logic [CNT_W-1:0]             k_r;
    logic [TAG_W-1:0]             tag_r;
    logic [IDX_W-1:0]             idx_r;
    logic [WAY_W-1:0]             way_r;
    logic [BLOCK_WORDS-1:0][31:0] buf_r;
    logic                         accept_s;

    assign accept_s = (state_r == FILL) && !iwait && !flush;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; flush always returns to IDLE
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (miss) next_s = FILL;
                else      next_s = IDLE;
            end
            FILL: begin
                if (flush)                        next_s = IDLE;
                else if (!iwait && k_r == LAST_K) next_s = COMMIT;
                else                              next_s = FILL;
            end
            COMMIT:  next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // Miss latch, word counter and fill buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            k_r   <= '0;
            tag_r <= '0;
            idx_r <= '0;
            way_r <= '0;
            buf_r <= '0;
        end else if (state_r == IDLE && miss) begin
            k_r   <= '0;
            tag_r <= miss_tag;
            idx_r <= miss_idx;
            way_r <= victim;
        end else if (accept_s) begin
            buf_r[k_r] <= iload;
            k_r        <= (k_r == LAST_K) ? '0 : k_r + CNT_W'(1);
        end
    end

    // Memory request and strobes decoded from the current state
    always_comb begin
        if (state_r == FILL) begin
            iren  = 1'b1;
            iaddr = (32'({tag_r, idx_r}) << (OFF_W + 2)) | (32'(k_r) << 2);
        end else begin
            iren  = 1'b0;
            iaddr = 32'd0;
        end
        commit = (state_r == COMMIT);
        abort  = flush && (state_r != IDLE);
    end

    assign state     = state_r;
    assign fill_tag  = tag_r;
    assign fill_idx  = idx_r;
    assign fill_way  = way_r;
    assign fill_data = buf_r;

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative, multi-word-block instruction cache with round-robin
// replacement and whole-cache flush. Define ICACHE_STATS_EN for hit/miss counters.
module icache_assoc
    import icache_pkg::*;
#(
    parameter int WAYS        = DEF_WAYS,
    parameter int SETS        = DEF_SETS,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        iflush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W - OFF_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int CNT_W = (OFF_W > 0) ? OFF_W : 1;

    logic                         valid_r [WAYS][SETS];
    logic [TAG_W-1:0]             tag_r   [WAYS][SETS];
    logic [BLOCK_WORDS-1:0][31:0] data_r  [WAYS][SETS];
    logic [WAY_W-1:0]             rr_r    [SETS];

    addr_split_t                  split_s;
    logic [TAG_W-1:0]             tag_s;
    logic [IDX_W-1:0]             idx_s;
    logic [CNT_W-1:0]             off_s;
    logic                         hit_any_s;
    logic [WAY_W-1:0]             hit_way_s;
    logic [WAY_W-1:0]             victim_s;
    logic                         miss_s;
    icache_state_t                state_s;
    logic                         commit_s, abort_s;
    logic [TAG_W-1:0]             fill_tag_s;
    logic [IDX_W-1:0]             fill_idx_s;
    logic [WAY_W-1:0]             fill_way_s;
    logic [BLOCK_WORDS-1:0][31:0] fill_data_s;

    assign split_s = split_addr(imemaddr, IDX_W, OFF_W);
    assign tag_s   = TAG_W'(split_s.tag);
    assign idx_s   = IDX_W'(split_s.idx);
    assign off_s   = CNT_W'(split_s.off);

    // Tag compare; the fill path never installs a duplicate, so OR-ing way numbers is exact
    always_comb begin
        hit_any_s = 1'b0;
        hit_way_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_any_s = hit_any_s | (valid_r[w][idx_s] && tag_r[w][idx_s] == tag_s);
            hit_way_s = hit_way_s | ({WAY_W{valid_r[w][idx_s] && tag_r[w][idx_s] == tag_s}} & WAY_W'(w));
        end
    end

    // Victim: lowest invalid way, otherwise the set's round-robin pointer
    always_comb begin
        victim_s = rr_r[idx_s];
        for (int w = WAYS - 1; w >= 0; w--) begin
            victim_s = valid_r[w][idx_s] ? victim_s : WAY_W'(w);
        end
    end

    assign ihit     = imemREN && hit_any_s;
    assign imemload = ihit ? data_r[hit_way_s][idx_s][off_s] : 32'd0;
    assign miss_s   = imemREN && !hit_any_s && !iflush && (state_s == IDLE);

    icache_fill_fsm #(
        .BLOCK_WORDS (BLOCK_WORDS),
        .IDX_W       (IDX_W),
        .TAG_W       (TAG_W),
        .WAY_W       (WAY_W)
    ) u_fill (
        .clk       (CLK),
        .rst       (RST),
        .flush     (iflush),
        .miss      (miss_s),
        .miss_tag  (tag_s),
        .miss_idx  (idx_s),
        .victim    (victim_s),
        .iwait     (iwait),
        .iload     (iload),
        .state     (state_s),
        .iren      (iREN),
        .iaddr     (iaddr),
        .commit    (commit_s),
        .abort     (abort_s),
        .fill_tag  (fill_tag_s),
        .fill_idx  (fill_idx_s),
        .fill_way  (fill_way_s),
        .fill_data (fill_data_s)
    );

    // Line array: flush beats commit; rr only advances when a valid line is displaced
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_r[w][s] <= 1'b0;
                    tag_r[w][s]   <= '0;
                    data_r[w][s]  <= '0;
                end
            end
            for (int s = 0; s < SETS; s++) begin
                rr_r[s] <= '0;
            end
        end else if (iflush) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_r[w][s] <= 1'b0;
                end
            end
        end else if (commit_s && !abort_s) begin
            valid_r[fill_way_s][fill_idx_s] <= 1'b1;
            tag_r[fill_way_s][fill_idx_s]   <= fill_tag_s;
            data_r[fill_way_s][fill_idx_s]  <= fill_data_s;
            if (valid_r[fill_way_s][fill_idx_s]) begin
                rr_r[fill_idx_s] <= WAY_W'((int'(fill_way_s) + 1) % WAYS);
            end
        end
    end

`ifdef ICACHE_STATS_EN
    // Saturating hit/miss statistics
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            if (ihit && hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            if (miss_s && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench for icache_assoc: directed scenarios followed by random
// fetch/flush/reset traffic against a line-level reference model.
module tb_icache_assoc;

    localparam int WAYS  = 2;
    localparam int SETS  = 8;
    localparam int BW    = 2;
    localparam int OFF_W = $clog2(BW);
    localparam int IDX_W = $clog2(SETS);

    logic        CLK = 1'b0;
    logic        RST, imemREN, iflush, iwait;
    logic [31:0] imemaddr, iload;
    logic        ihit, iREN;
    logic [31:0] imemload, iaddr;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    bit          m_valid [WAYS][SETS];
    logic [31:0] m_tag   [WAYS][SETS];
    logic [31:0] m_data  [WAYS][SETS][BW];
    int          m_rr    [SETS];

    icache_assoc #(.WAYS(WAYS), .SETS(SETS), .BLOCK_WORDS(BW)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .iflush   (iflush),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hAAAA_0001;
    endfunction

    function automatic int a_idx(input logic [31:0] a);
        return int'((a >> (2 + OFF_W)) % SETS);
    endfunction

    function automatic logic [31:0] a_tag(input logic [31:0] a);
        return a >> (2 + OFF_W + IDX_W);
    endfunction

    function automatic logic [31:0] blk_base(input logic [31:0] a);
        return a & ~(32'(BW * 4) - 32'd1);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic model_lookup(input logic [31:0] a, output bit hit, output logic [31:0] d);
        hit = 1'b0;
        d   = 32'd0;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[w][a_idx(a)] && m_tag[w][a_idx(a)] == a_tag(a)) begin
                hit = 1'b1;
                d   = m_data[w][a_idx(a)][int'((a >> 2) % BW)];
            end
        end
    endtask

    task automatic model_reset;
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[w][s] = 1'b0;
        end
    endtask

    task automatic model_flush;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) m_valid[w][s] = 1'b0;
    endtask

    function automatic int model_victim(input int s);
        for (int w = 0; w < WAYS; w++)
            if (!m_valid[w][s]) return w;
        return m_rr[s];
    endfunction

    task automatic model_install(input logic [31:0] a, input int v);
        int s = a_idx(a);
        if (m_valid[v][s]) m_rr[s] = (v + 1) % WAYS;
        m_valid[v][s] = 1'b1;
        m_tag[v][s]   = a_tag(a);
        for (int k = 0; k < BW; k++) m_data[v][s][k] = mem_word(blk_base(a) + 32'(4 * k));
    endtask

    task automatic do_reset(input bit with_flush);
        RST = 1'b1; iflush = with_flush; imemREN = 1'b0; iwait = 1'b1;
        iload = 32'd0; imemaddr = 32'd0;
        tick;
        RST = 1'b0; iflush = 1'b0;
        model_reset;
        @(negedge CLK);
        check_val("rst_iren", {31'd0, iREN}, 32'd0);
        check_val("rst_iaddr", iaddr, 32'd0);
        check_val("rst_ihit", {31'd0, ihit}, 32'd0);
        check_val("rst_imemload", imemload, 32'd0);
        tick;
    endtask

    task automatic do_flush(input logic [31:0] a);
        iflush = 1'b1; imemREN = 1'b1; imemaddr = a;
        tick;
        iflush = 1'b0; imemREN = 1'b0;
        model_flush;
        @(negedge CLK);
        check_val("flush_no_fill", {31'd0, iREN}, 32'd0);
        tick;
    endtask

    task automatic probe(input logic [31:0] a, input bit exp_hit);
        bit mh;
        logic [31:0] md;
        imemREN = 1'b1; imemaddr = a;
        @(negedge CLK);
        model_lookup(a, mh, md);
        check_val("probe_model", {31'd0, ihit}, {31'd0, mh});
        check_val("probe_exp", {31'd0, ihit}, {31'd0, exp_hit});
        imemREN = 1'b0;
        @(negedge CLK);
        check_val("gated_ihit", {31'd0, ihit}, 32'd0);
        check_val("gated_load", imemload, 32'd0);
        tick;
    endtask

    // One fetch; on a miss walks the fill, optionally stalling, redirecting
    // imemaddr, or aborting by flush/reset when word abort_k is requested.
    task automatic fetch(input logic [31:0] a, input int stall_pct, input int stall0,
                         input bit use_alt, input logic [31:0] alt,
                         input int abort_k, input bit abort_rst);
        bit          mh;
        logic [31:0] md, exp_addr;
        int          k, lat, nst, st0, budget, v;
        imemREN = 1'b1; imemaddr = a; iflush = 1'b0; iwait = 1'b1;
        @(negedge CLK);
        model_lookup(a, mh, md);
        check_val("lookup_hit", {31'd0, ihit}, {31'd0, mh});
        if (mh) begin
            check_val("hit_load", imemload, md);
            tick;
            imemREN = 1'b0;
            return;
        end
        check_val("miss_load", imemload, 32'd0);
        check_val("idle_iren", {31'd0, iREN}, 32'd0);
        v = model_victim(a_idx(a));
        tick;
        lat = 1; k = 0; nst = 0; st0 = stall0; budget = 0;
        while (k < BW) begin
            if (use_alt) imemaddr = alt;
            iwait = ($urandom_range(0, 99) < stall_pct) || (st0 > 0) || (k == abort_k);
            exp_addr = blk_base(a) + 32'(4 * k);
            iload = mem_word(exp_addr);
            @(negedge CLK);
            check_val("fill_iren", {31'd0, iREN}, 32'd1);
            check_val("fill_iaddr", iaddr, exp_addr);
            model_lookup(imemaddr, mh, md);
            check_val("fill_ihit", {31'd0, ihit}, {31'd0, mh});
            if (k == abort_k) begin
                if (abort_rst) RST = 1'b1;
                else           iflush = 1'b1;
                tick;
                RST = 1'b0; iflush = 1'b0; imemREN = 1'b0;
                if (abort_rst) model_reset;
                else           model_flush;
                @(negedge CLK);
                check_val("abort_iren", {31'd0, iREN}, 32'd0);
                if (abort_rst) check_val("abort_rst_iaddr", iaddr, 32'd0);
                tick;
                return;
            end
            tick;
            lat++;
            if (iwait) nst++;
            else       k++;
            if (st0 > 0) st0--;
            budget++;
            if (budget > 400) begin
                check_val("fill_timeout", 32'(k), 32'(BW));
                imemREN = 1'b0;
                return;
            end
        end
        imemaddr = a; iwait = 1'b1;
        @(negedge CLK);
        check_val("commit_iren", {31'd0, iREN}, 32'd0);
        check_val("commit_ihit", {31'd0, ihit}, 32'd0);
        tick;
        lat++;
        model_install(a, v);
        model_lookup(a, mh, md);
        @(negedge CLK);
        check_val("post_fill_hit", {31'd0, ihit}, 32'd1);
        check_val("post_fill_load", imemload, md);
        check_val("miss_latency", 32'(lat), 32'(BW + 2 + nst));
        tick;
        imemREN = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr;
        return (32'($urandom_range(0, 3)) << (2 + OFF_W + IDX_W)) |
               (32'($urandom_range(0, SETS - 1)) << (2 + OFF_W)) |
               (32'($urandom_range(0, BW - 1)) << 2);
    endfunction

    initial begin
        int r;
        do_reset(1'b0);
        // cold miss, then the sibling word hits
        fetch(32'h40, 0, 0, 1'b0, 32'd0, -1, 1'b0);
        fetch(32'h44, 0, 0, 1'b0, 32'd0, -1, 1'b0);
        // conflict in set 0 across both ways, then round-robin eviction of way 0
        fetch(32'h440, 0, 0, 1'b0, 32'd0, -1, 1'b0);
        probe(32'h040, 1'b1);
        fetch(32'h840, 0, 0, 1'b0, 32'd0, -1, 1'b0);
        probe(32'h040, 1'b0);
        probe(32'h440, 1'b1);
        // three-cycle stall on word 0
        do_reset(1'b0);
        fetch(32'h40, 0, 3, 1'b0, 32'd0, -1, 1'b0);
        // flush after word 0 accepted
        do_reset(1'b0);
        fetch(32'h80, 0, 0, 1'b0, 32'd0, -1, 1'b0);
        fetch(32'h40, 0, 0, 1'b0, 32'd0, 1, 1'b0);
        probe(32'h40, 1'b0);
        probe(32'h80, 1'b0);
        // reset mid-fill, then a full refill
        fetch(32'h80, 0, 0, 1'b0, 32'd0, -1, 1'b0);
        fetch(32'h40, 0, 0, 1'b0, 32'd0, 1, 1'b1);
        probe(32'h80, 1'b0);
        fetch(32'h40, 0, 0, 1'b0, 32'd0, -1, 1'b0);
        // address redirected during fill
        do_reset(1'b0);
        fetch(32'h40, 0, 0, 1'b1, 32'h80, -1, 1'b0);
        probe(32'h80, 1'b0);
        fetch(32'h80, 0, 0, 1'b0, 32'd0, -1, 1'b0);
        probe(32'h40, 1'b1);
        // reset and flush together
        do_reset(1'b1);
        probe(32'h40, 1'b0);
        // random traffic
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 4)       do_flush(rand_addr());
            else if (r < 8)  fetch(rand_addr(), 20, 0, 1'b0, 32'd0, $urandom_range(0, BW - 1), 1'b0);
            else if (r < 10) fetch(rand_addr(), 20, 0, 1'b0, 32'd0, $urandom_range(0, BW - 1), 1'b1);
            else if (r < 25) fetch(rand_addr(), 25, 0, 1'b1, rand_addr(), -1, 1'b0);
            else             fetch(rand_addr(), 25, 0, 1'b0, 32'd0, -1, 1'b0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, %0d failed so far", n_fail);
        $fatal(1);
    end

endmodule
